fetch_redirect: RTL and testbench
=================================

Name: fetch_redirect

Overview:
Fetch-stage PC generator for the pipelined processor. It is the consumer of the taken-branch decision (pcSrc) produced by execute-stage condition logic. It owns the fetch PC and the instruction-memory request handshake. It applies branch redirects, generates decode/execute flushes, and safely discards an in-flight fetch that a redirect has made stale.

Parameters:
ADDR_W, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, fetch address after reset
INC, 4, sequential PC increment in bytes; power of two
ALIGN_BITS, 2, log2(INC); target low bits that must be zero

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
pcSrc  in  1  taken branch/jump resolved in EX this cycle
branchTarget  in  ADDR_W  redirect address, valid when pcSrc=1
stallF  in  1  hazard unit: decode cannot accept an instruction
imemReady  in  1  instruction memory returns data for imemAddr this cycle
imemReq  out  1  fetch request; held until imemReady
imemAddr  out  ADDR_W  address of current request
pcF  out  ADDR_W  PC of instruction being fetched
pcPlus4F  out  ADDR_W  pcF+INC, wraps modulo 2^ADDR_W
instrValidF  out  1  fetched instruction accepted into decode this cycle
flushD  out  1  kill decode register contents
flushE  out  1  kill execute register contents
redirectPending  out  1  stale fetch being drained
alignErr  out  1  sticky: misaligned branchTarget seen
branchCount  out  16  saturating count of taken redirects

Behaviour:
- Reset (sync, active-high) values: pcF=RESET_PC, state=FETCH, pendingTarget=0, alignErr=0, branchCount=0.
- While reset=1, all combinational outputs are forced to 0: imemReq, instrValidF, flushD, flushE, redirectPending.
- The first request, to RESET_PC, is issued in the first cycle after reset deasserts.
- Reset mid-DRAIN abandons the pending target. The memory response is the memory's concern.
- States: FETCH, DRAIN.
- imemReq=1 in both states.
- imemAddr=pcF in both states. In DRAIN, pcF still holds the stale in-flight address.
- redirectPending=1 iff state=DRAIN.
- flushD=flushE=pcSrc, combinational, same cycle, in any state.
- instrValidF = FETCH & imemReady & ~stallF & ~pcSrc.
- Effective target = branchTarget with low ALIGN_BITS forced to 0.
- If pcSrc=1 and branchTarget low ALIGN_BITS are nonzero, set alignErr. It stays set until reset.
- FETCH transitions, in priority order:
  - pcSrc & imemReady: response discarded; pcF<=target; stay FETCH.
  - pcSrc & ~imemReady: pendingTarget<=target; go to DRAIN. The request cannot be aborted.
  - imemReady & ~stallF: pcF<=pcF+INC (accepted).
  - imemReady & stallF: pcF unchanged; same address re-requested next cycle. The memory is read-idempotent.
  - ~imemReady: hold.
- DRAIN transitions:
  - pcSrc & imemReady: response discarded; pcF<=new target; go to FETCH.
  - pcSrc & ~imemReady: pendingTarget<=new target; latest redirect wins.
  - ~pcSrc & imemReady: response discarded; pcF<=pendingTarget; go to FETCH.
  - otherwise: hold.
  - instrValidF is never 1 in DRAIN.
- Redirect has priority over stallF: pcF updates even while stalled.
- branchCount increments on every reset-free cycle with pcSrc=1. It saturates at 16'hFFFF.
- Latency: the redirected address appears on imemAddr the cycle after pcSrc in FETCH+ready. In DRAIN it appears the cycle after the stale response.
- PC arithmetic is modulo 2^ADDR_W: pcF=FFFF_FFFC, INC=4, accepted -> 0000_0000.

Test Plan:
- Reset release, imemReady=1, stallF=0 for 4 cycles -> imemAddr 0,4,8,C; instrValidF=1 each cycle; flushD=flushE=0.
- pcF=0x10, imemReady=1, stallF=1 for 3 cycles -> imemAddr stays 0x10, instrValidF=0. Release stallF -> pcF 0x14.
- pcF=0x20, pcSrc=1, branchTarget=0x100, imemReady=1 -> flushD=flushE=1, instrValidF=0. Next cycle imemAddr=0x100; branchCount=1.
- pcF=0x20, imemReady=0, pcSrc=1, target=0x200 -> DRAIN, imemAddr stays 0x20, redirectPending=1. Two cycles later pcSrc=1, target=0x300, then imemReady=1 -> instrValidF=0; next imemAddr=0x300.
- pcSrc=1 with branchTarget=0x103 -> next pcF=0x100, alignErr=1. It stays 1 through further fetches until reset.
- pcF=FFFF_FFFC accepted -> pcF=0, pcPlus4F=4. Assert reset during DRAIN -> next cycle imemReq=0, pcF=RESET_PC, redirectPending=0.

Source files
------------

// File: rtl/fetch_redirect.sv
// rtl/fetch_redirect.sv - fetch-stage PC generator with branch redirect and stale-fetch drain
// A redirect that arrives while a request is outstanding parks its target until the stale response returns.
module fetch_redirect #(
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0,
   parameter int                INC        = 4,
   parameter int                ALIGN_BITS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pcSrc,
   input  logic [ADDR_W-1:0] branchTarget,
   input  logic              stallF,
   input  logic              imemReady,
   output logic              imemReq,
   output logic [ADDR_W-1:0] imemAddr,
   output logic [ADDR_W-1:0] pcF,
   output logic [ADDR_W-1:0] pcPlus4F,
   output logic              instrValidF,
   output logic              flushD,
   output logic              flushE,
   output logic              redirectPending,
   output logic              alignErr,
   output logic [15:0]       branchCount
);

   typedef enum logic {FETCH, DRAIN} stateT;

   localparam logic [ADDR_W-1:0] INC_V    = ADDR_W'(INC);
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << ALIGN_BITS) - 64'd1);

   stateT             state;
   logic [ADDR_W-1:0] pendingTarget;
   logic [ADDR_W-1:0] target;
   logic              misaligned;

   assign target     = branchTarget & ~LOW_MASK;
   assign misaligned = |(branchTarget & LOW_MASK);

   assign imemReq         = ~reset;
   assign imemAddr        = pcF;
   assign pcPlus4F        = pcF + INC_V;
   assign flushD          = pcSrc & ~reset;
   assign flushE          = pcSrc & ~reset;
   assign redirectPending = ~reset & (state == DRAIN);
   assign instrValidF     = ~reset & (state == FETCH) & imemReady & ~stallF & ~pcSrc;

   always_ff @(posedge clk) begin
      if (reset) begin
         pcF           <= RESET_PC;
         state         <= FETCH;
         pendingTarget <= '0;
         alignErr      <= 1'b0;
         branchCount   <= 16'd0;
      end else begin
         if (pcSrc && misaligned)
            alignErr <= 1'b1;
         if (pcSrc && branchCount != 16'hFFFF)
            branchCount <= branchCount + 16'd1;

         case (state)
            FETCH: begin
               if (pcSrc && imemReady) begin
                  pcF <= target;
               end else if (pcSrc) begin
                  // The outstanding request cannot be withdrawn; wait for its response.
                  pendingTarget <= target;
                  state         <= DRAIN;
               end else if (imemReady && !stallF) begin
                  pcF <= pcF + INC_V;
               end
            end
            DRAIN: begin
               if (pcSrc && imemReady) begin
                  pcF   <= target;
                  state <= FETCH;
               end else if (pcSrc) begin
                  pendingTarget <= target;
               end else if (imemReady) begin
                  pcF   <= pendingTarget;
                  state <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_redirect.sv
// tb/tb_fetch_redirect.sv - table-driven scoreboard bench for fetch_redirect
module tb_fetch_redirect;

   typedef struct {
      int          id;
      logic        rst;
      logic        src;
      logic [31:0] tgt;
      logic        stall;
      logic        rdy;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic        flush;
      logic        pend;
      logic        align;
      logic [15:0] cnt;
   } vecT;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        pcSrc = 1'b0;
   logic [31:0] branchTarget = '0;
   logic        stallF = 1'b0;
   logic        imemReady = 1'b0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic [31:0] pcF;
   logic [31:0] pcPlus4F;
   logic        instrValidF;
   logic        flushD;
   logic        flushE;
   logic        redirectPending;
   logic        alignErr;
   logic [15:0] branchCount;

   int  nCompared = 0;
   int  nMismatch = 0;
   vecT expQ[$];
   vecT tbl[$];
   vecT monE;

   fetch_redirect dut (
      .clk(clk), .reset(reset), .pcSrc(pcSrc), .branchTarget(branchTarget),
      .stallF(stallF), .imemReady(imemReady), .imemReq(imemReq), .imemAddr(imemAddr),
      .pcF(pcF), .pcPlus4F(pcPlus4F), .instrValidF(instrValidF), .flushD(flushD),
      .flushE(flushE), .redirectPending(redirectPending), .alignErr(alignErr),
      .branchCount(branchCount)
   );

   always #5 clk = ~clk;

   function automatic vecT mk(int id, logic rst, logic src, logic [31:0] tgt, logic stall,
                              logic rdy, logic req, logic [31:0] addr, logic valid,
                              logic flush, logic pend, logic align, logic [15:0] cnt);
      vecT v;
      v.id = id; v.rst = rst; v.src = src; v.tgt = tgt; v.stall = stall; v.rdy = rdy;
      v.req = req; v.addr = addr; v.valid = valid; v.flush = flush; v.pend = pend;
      v.align = align; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(string nm, int id, logic [31:0] act, logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatch++;
         $display("FAIL row %0d %s: got %h expected %h", id, nm, act, exp);
      end
   endtask

   task automatic applyVec(vecT v);
      @(negedge clk);
      reset        = v.rst;
      pcSrc        = v.src;
      branchTarget = v.tgt;
      stallF       = v.stall;
      imemReady    = v.rdy;
      expQ.push_back(v);
   endtask

   always @(negedge clk) begin
      #2;
      if (expQ.size() != 0) begin
         monE = expQ.pop_front();
         chk("imemReq",         monE.id, 32'(imemReq),         32'(monE.req));
         chk("imemAddr",        monE.id, imemAddr,             monE.addr);
         chk("pcF",             monE.id, pcF,                  monE.addr);
         chk("pcPlus4F",        monE.id, pcPlus4F,             monE.addr + 32'd4);
         chk("instrValidF",     monE.id, 32'(instrValidF),     32'(monE.valid));
         chk("flushD",          monE.id, 32'(flushD),          32'(monE.flush));
         chk("flushE",          monE.id, 32'(flushE),          32'(monE.flush));
         chk("redirectPending", monE.id, 32'(redirectPending), 32'(monE.pend));
         chk("alignErr",        monE.id, 32'(alignErr),        32'(monE.align));
         chk("branchCount",     monE.id, 32'(branchCount),     32'(monE.cnt));
      end
   end

   initial begin
      //              id rst src tgt            stl rdy req addr           vld fl pnd aln cnt
      tbl.push_back(mk( 0, 1, 0, 32'h0,          0, 1,  0, 32'h0,          0, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 1, 1, 1, 32'h40,         0, 1,  0, 32'h0,          0, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 2, 0, 0, 32'h0,          0, 1,  1, 32'h0,          1, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 3, 0, 0, 32'h0,          0, 1,  1, 32'h4,          1, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 4, 0, 0, 32'h0,          0, 1,  1, 32'h8,          1, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 5, 0, 0, 32'h0,          0, 1,  1, 32'hC,          1, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 6, 0, 0, 32'h0,          1, 1,  1, 32'h10,         0, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 7, 0, 0, 32'h0,          1, 1,  1, 32'h10,         0, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 8, 0, 0, 32'h0,          1, 1,  1, 32'h10,         0, 0, 0, 0, 16'd0));
      tbl.push_back(mk( 9, 0, 0, 32'h0,          0, 1,  1, 32'h10,         1, 0, 0, 0, 16'd0));
      tbl.push_back(mk(10, 0, 0, 32'h0,          0, 1,  1, 32'h14,         1, 0, 0, 0, 16'd0));
      tbl.push_back(mk(11, 0, 0, 32'h0,          0, 1,  1, 32'h18,         1, 0, 0, 0, 16'd0));
      tbl.push_back(mk(12, 0, 0, 32'h0,          0, 1,  1, 32'h1C,         1, 0, 0, 0, 16'd0));
      tbl.push_back(mk(13, 0, 1, 32'h100,        1, 1,  1, 32'h20,         0, 1, 0, 0, 16'd0));
      tbl.push_back(mk(14, 0, 0, 32'h0,          0, 1,  1, 32'h100,        1, 0, 0, 0, 16'd1));
      tbl.push_back(mk(15, 0, 1, 32'h20,         0, 1,  1, 32'h104,        0, 1, 0, 0, 16'd1));
      tbl.push_back(mk(16, 0, 1, 32'h200,        0, 0,  1, 32'h20,         0, 1, 0, 0, 16'd2));
      tbl.push_back(mk(17, 0, 0, 32'h0,          0, 0,  1, 32'h20,         0, 0, 1, 0, 16'd3));
      tbl.push_back(mk(18, 0, 0, 32'h0,          0, 0,  1, 32'h20,         0, 0, 1, 0, 16'd3));
      tbl.push_back(mk(19, 0, 1, 32'h300,        0, 0,  1, 32'h20,         0, 1, 1, 0, 16'd3));
      tbl.push_back(mk(20, 0, 0, 32'h0,          0, 1,  1, 32'h20,         0, 0, 1, 0, 16'd4));
      tbl.push_back(mk(21, 0, 0, 32'h0,          0, 1,  1, 32'h300,        1, 0, 0, 0, 16'd4));
      tbl.push_back(mk(22, 0, 1, 32'h400,        0, 0,  1, 32'h304,        0, 1, 0, 0, 16'd4));
      tbl.push_back(mk(23, 0, 1, 32'h500,        0, 1,  1, 32'h304,        0, 1, 1, 0, 16'd5));
      tbl.push_back(mk(24, 0, 1, 32'h103,        0, 1,  1, 32'h500,        0, 1, 0, 0, 16'd6));
      tbl.push_back(mk(25, 0, 0, 32'h0,          0, 1,  1, 32'h100,        1, 0, 0, 1, 16'd7));
      tbl.push_back(mk(26, 0, 0, 32'h0,          0, 1,  1, 32'h104,        1, 0, 0, 1, 16'd7));
      tbl.push_back(mk(27, 0, 1, 32'hFFFF_FFFC,  0, 1,  1, 32'h108,        0, 1, 0, 1, 16'd7));
      tbl.push_back(mk(28, 0, 0, 32'h0,          0, 1,  1, 32'hFFFF_FFFC,  1, 0, 0, 1, 16'd8));
      tbl.push_back(mk(29, 0, 0, 32'h0,          0, 1,  1, 32'h0,          1, 0, 0, 1, 16'd8));
      tbl.push_back(mk(30, 0, 1, 32'h40,         0, 0,  1, 32'h4,          0, 1, 0, 1, 16'd8));
      tbl.push_back(mk(31, 1, 1, 32'h40,         0, 1,  0, 32'h4,          0, 0, 0, 1, 16'd9));
      tbl.push_back(mk(32, 0, 0, 32'h0,          0, 0,  1, 32'h0,          0, 0, 0, 0, 16'd0));
      tbl.push_back(mk(33, 0, 0, 32'h0,          0, 1,  1, 32'h0,          1, 0, 0, 0, 16'd0));
      tbl.push_back(mk(34, 0, 0, 32'h0,          0, 1,  1, 32'h4,          1, 0, 0, 0, 16'd0));

      for (int i = 0; i < tbl.size(); i++)
         applyVec(tbl[i]);

      // Saturation: continuous redirects to 0x80 bring the counter to FFFE unchecked.
      for (int i = 0; i < 65534; i++) begin
         @(negedge clk);
         reset = 1'b0; pcSrc = 1'b1; branchTarget = 32'h80; stallF = 1'b0; imemReady = 1'b1;
      end
      applyVec(mk(100, 0, 1, 32'h80, 0, 1, 1, 32'h80, 0, 1, 0, 0, 16'hFFFE));
      applyVec(mk(101, 0, 1, 32'h80, 0, 1, 1, 32'h80, 0, 1, 0, 0, 16'hFFFF));
      applyVec(mk(102, 0, 0, 32'h0,  0, 1, 1, 32'h80, 1, 0, 0, 0, 16'hFFFF));
      applyVec(mk(103, 0, 0, 32'h0,  0, 1, 1, 32'h84, 1, 0, 0, 0, 16'hFFFF));

      @(negedge clk);
      #5;
      nCompared++;
      if (expQ.size() != 0) begin
         nMismatch++;
         $display("FAIL scoreboard drain: got %0d entries left expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
